// File: rtl/prga_fifo_rr_drain_if.sv
// prga_fifo_rr_drain_if: upstream lookahead FIFOs, downstream FIFO write port and grant status
interface prga_fifo_rr_drain_if #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
);
   logic [NUM_SRC-1:0]            src_en;
   logic [NUM_SRC-1:0]            src_empty;
   logic [NUM_SRC-1:0]            src_rd;
   logic [NUM_SRC*DATA_WIDTH-1:0] src_dout;
   logic                          dst_full;
   logic                          dst_wr;
   logic [DATA_WIDTH-1:0]         dst_din;
   logic                          grant_valid;
   logic [ID_WIDTH-1:0]           grant_id;

   modport slave (
      input  src_en, src_empty, src_dout, dst_full,
      output src_rd, dst_wr, dst_din, grant_valid, grant_id
   );

   modport master (
      output src_en, src_empty, src_dout, dst_full,
      input  src_rd, dst_wr, dst_din, grant_valid, grant_id
   );
endinterface

// File: rtl/prga_fifo_rr_drain.sv
// prga_fifo_rr_drain: round-robin drain of several lookahead FIFOs into one FIFO, bursts of up to BURST_LEN words
module prga_fifo_rr_drain #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4,
   localparam int ID_WIDTH  = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
   input logic clk,
   input logic rst,
   prga_fifo_rr_drain_if.slave bus
);
   localparam int CNT_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               state;
   logic [ID_WIDTH-1:0]  rr_ptr;
   logic [ID_WIDTH-1:0]  grant_id;
   logic [ID_WIDTH-1:0]  pick;
   logic [CNT_WIDTH-1:0] burst_cnt;
   logic                 grant_valid;
   logic [NUM_SRC-1:0]   req;
   logic                 g_ok;
   logic                 xfer;
   logic                 last;

   // explicit modulo so a non-power-of-two NUM_SRC wraps correctly
   function automatic logic [ID_WIDTH-1:0] wrap(input int v);
      return ID_WIDTH'(v >= NUM_SRC ? v - NUM_SRC : v);
   endfunction

   // eligibility, rotating priority pick and the combinational transfer strobe
   always_comb begin
      req = bus.src_en & ~bus.src_empty;
      pick = rr_ptr;
      for (int k = NUM_SRC - 1; k >= 0; k--)
         if (req[wrap(int'(rr_ptr) + k)]) pick = wrap(int'(rr_ptr) + k);
      g_ok = state == GRANT && req[grant_id] && !rst;
      xfer = g_ok && !bus.dst_full;
      last = burst_cnt == CNT_WIDTH'(BURST_LEN - 1);
   end

   assign bus.src_rd      = xfer ? (NUM_SRC'(1) << grant_id) : '0;
   assign bus.dst_wr      = xfer;
   assign bus.dst_din     = bus.src_dout[grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign bus.grant_valid = grant_valid;
   assign bus.grant_id    = grant_id;

   // grant FSM: hold for a burst, drop on burst end or a dried-up/disabled source, stall on full
   always_ff @(posedge clk)
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         burst_cnt   <= '0;
      end else if (state == IDLE) begin
         if (|req) begin
            state       <= GRANT;
            grant_id    <= pick;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
         end
      end else if (xfer && !last) begin
         burst_cnt <= burst_cnt + 1'b1;
      end else if (xfer || !g_ok) begin
         state       <= IDLE;
         grant_valid <= 1'b0;
         burst_cnt   <= '0;
         rr_ptr      <= wrap(int'(grant_id) + 1);
      end
endmodule

// File: tb/tb_prga_fifo_rr_drain.sv
// tb_prga_fifo_rr_drain: directed scenarios with queue-modelled FIFOs and a downstream scoreboard
module tb_prga_fifo_rr_drain;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   prga_fifo_rr_drain_if #(.NUM_SRC(4), .DATA_WIDTH(8), .ID_WIDTH(2)) ifa ();
   prga_fifo_rr_drain_if #(.NUM_SRC(3), .DATA_WIDTH(8), .ID_WIDTH(2)) ifb ();

   prga_fifo_rr_drain #(.NUM_SRC(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   prga_fifo_rr_drain #(.NUM_SRC(3), .DATA_WIDTH(8), .BURST_LEN(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   logic [7:0] qa [4][$];
   logic [7:0] qb [3][$];
   logic [9:0] exp_a [$];
   logic [9:0] exp_b [$];
   logic [1:0] glog_a [$];
   logic [1:0] glog_b [$];
   logic [7:0] t1 [6] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2};
   logic [9:0] wr_pat = 10'b0011011110;
   logic [9:0] gv_pat = 10'b0111011110;
   int n_assert = 0;
   int n_fail = 0;
   int n_wr_a = 0;
   int n_wr_b = 0;
   logic pgv_a = 1'b0;
   logic pgv_b = 1'b0;
   logic [3:0] rd_a;
   logic [2:0] rd_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         ifa.src_empty[i] = qa[i].size() == 0;
         ifa.src_dout[i*8 +: 8] = (qa[i].size() != 0) ? qa[i][0] : 8'h00;
      end
      for (int i = 0; i < 3; i++) begin
         ifb.src_empty[i] = qb[i].size() == 0;
         ifb.src_dout[i*8 +: 8] = (qb[i].size() != 0) ? qb[i][0] : 8'h00;
      end
   endtask

   task automatic load_a(input int s, input int n, input logic [7:0] base, input int n_exp);
      for (int k = 0; k < n; k++) qa[s].push_back(base + 8'(k));
      for (int k = 0; k < n_exp; k++) exp_a.push_back({2'(s), base + 8'(k)});
   endtask

   // one clock: score writes mid-cycle, then pop the source models on the edge
   task automatic step();
      logic [9:0] e;
      #1;
      if (ifa.dst_wr === 1'b1) begin
         n_wr_a++;
         chk("a_wr_while_full", ifa.dst_full, 0);
         if (exp_a.size() == 0) chk("a_unexpected_wr", {ifa.grant_id, ifa.dst_din}, 32'hFFFF_FFFF);
         else begin
            e = exp_a.pop_front();
            chk("a_word", {ifa.grant_id, ifa.dst_din}, e);
         end
      end
      if (ifb.dst_wr === 1'b1) begin
         n_wr_b++;
         if (exp_b.size() == 0) chk("b_unexpected_wr", {ifb.grant_id, ifb.dst_din}, 32'hFFFF_FFFF);
         else begin
            e = exp_b.pop_front();
            chk("b_word", {ifb.grant_id, ifb.dst_din}, e);
         end
      end
      if (ifa.grant_valid && !pgv_a) glog_a.push_back(ifa.grant_id);
      if (ifb.grant_valid && !pgv_b) glog_b.push_back(ifb.grant_id);
      pgv_a = ifa.grant_valid;
      pgv_b = ifb.grant_valid;
      rd_a = ifa.src_rd;
      rd_b = ifb.src_rd;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (rd_a[i] && qa[i].size() != 0) void'(qa[i].pop_front());
      for (int i = 0; i < 3; i++) if (rd_b[i] && qb[i].size() != 0) void'(qb[i].pop_front());
      refresh();
      @(negedge clk);
   endtask

   task automatic drain_a(input int limit);
      for (int c = 0; c < limit && exp_a.size() != 0; c++) step();
      repeat (3) step();
      chk("a_drained", exp_a.size(), 0);
   endtask

   task automatic wait_wr_a(input int n);
      for (int c = 0; c < 30 && n_wr_a < n; c++) step();
      chk("a_wait_writes", n_wr_a, n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ifa.src_en = 4'hF;
      ifa.dst_full = 1'b0;
      ifb.src_en = 3'h7;
      ifb.dst_full = 1'b0;
      for (int k = 0; k < 6; k++) begin
         qa[0].push_back(t1[k]);
         exp_a.push_back({2'd0, t1[k]});
      end
      refresh();
      @(negedge clk);
      // reset with data waiting: nothing may move
      repeat (3) begin
         #1;
         chk("rst_grant_valid", ifa.grant_valid, 0);
         chk("rst_grant_id", ifa.grant_id, 0);
         chk("rst_dst_wr", ifa.dst_wr, 0);
         chk("rst_src_rd", ifa.src_rd, 0);
         chk("rst_b_grant_valid", ifb.grant_valid, 0);
         step();
      end
      // 1: single source, 4-word burst, one IDLE cycle, then the 2-word tail
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("t1_dst_wr", ifa.dst_wr, wr_pat[c]);
         chk("t1_grant_valid", ifa.grant_valid, gv_pat[c]);
         step();
      end
      chk("t1_exp_empty", exp_a.size(), 0);
      chk("t1_grants", glog_a.size(), 2);
      chk("t1_grant0", glog_a[0], 0);
      chk("t1_grant1", glog_a[1], 0);
      // 2: four full sources, fresh pointer, two full rotations
      rst = 1'b1;
      for (int s = 0; s < 4; s++) load_a(s, 8, 8'(s * 16), 0);
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++) exp_a.push_back({2'(s), 8'(s * 16 + r * 4 + k)});
      refresh();
      step();
      rst = 1'b0;
      glog_a.delete();
      drain_a(200);
      chk("t2_grants", glog_a.size(), 8);
      for (int j = 0; j < 8 && j < glog_a.size(); j++) chk("t2_grant_order", glog_a[j], j % 4);
      // 3: downstream full for 5 cycles after the 2nd write holds the grant
      n_wr_a = 0;
      glog_a.delete();
      load_a(2, 4, 8'hA0, 4);
      refresh();
      wait_wr_a(2);
      ifa.dst_full = 1'b1;
      repeat (5) begin
         #1;
         chk("t3_grant_valid", ifa.grant_valid, 1);
         chk("t3_grant_id", ifa.grant_id, 2);
         chk("t3_no_wr", ifa.dst_wr, 0);
         chk("t3_no_rd", ifa.src_rd, 0);
         step();
      end
      ifa.dst_full = 1'b0;
      drain_a(40);
      chk("t3_writes", n_wr_a, 4);
      chk("t3_grants", glog_a.size(), 1);
      // 4: enable mask excludes source 3, then source 1 is disabled mid-burst
      n_wr_a = 0;
      glog_a.delete();
      ifa.src_en = 4'b0111;
      load_a(1, 8, 8'h10, 2);
      load_a(3, 4, 8'h30, 0);
      refresh();
      wait_wr_a(2);
      ifa.src_en = 4'b0101;
      #1;
      chk("t4_drop_no_wr", ifa.dst_wr, 0);
      chk("t4_drop_no_rd", ifa.src_rd, 0);
      chk("t4_drop_gv", ifa.grant_valid, 1);
      step();
      repeat (5) begin
         #1;
         chk("t4_no_grant", ifa.grant_valid, 0);
         step();
      end
      chk("t4_only_src1", glog_a.size(), 1);
      chk("t4_src1", glog_a[0], 1);
      ifa.src_en = 4'b1101;
      for (int k = 0; k < 4; k++) exp_a.push_back({2'd3, 8'(8'h30 + k)});
      drain_a(40);
      chk("t4_grants", glog_a.size(), 2);
      chk("t4_src3", glog_a[1], 3);
      chk("t4_src1_left", qa[1].size(), 6);
      qa[1].delete();
      ifa.src_en = 4'hF;
      refresh();
      // 5: reset pulse mid-burst restarts arbitration from source 0
      load_a(1, 2, 8'h18, 2);
      refresh();
      drain_a(30);
      n_wr_a = 0;
      glog_a.delete();
      load_a(0, 6, 8'h40, 6);
      for (int k = 0; k < 2; k++) exp_a.push_back({2'd3, 8'(8'h70 + k)});
      refresh();
      wait_wr_a(2);
      rst = 1'b1;
      load_a(3, 2, 8'h70, 0);
      refresh();
      #1;
      chk("t5_rst_no_wr", ifa.dst_wr, 0);
      chk("t5_rst_no_rd", ifa.src_rd, 0);
      step();
      rst = 1'b0;
      #1;
      chk("t5_after_gv", ifa.grant_valid, 0);
      chk("t5_after_wr", ifa.dst_wr, 0);
      chk("t5_after_rd", ifa.src_rd, 0);
      drain_a(60);
      chk("t5_writes", n_wr_a, 8);
      chk("t5_grants", glog_a.size(), 3);
      if (glog_a.size() == 3) begin
         chk("t5_regrant0", glog_a[1], 0);
         chk("t5_then3", glog_a[2], 3);
      end
      // 6: three sources, single-word bursts, strict rotation with IDLE gaps
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 3; k++) qb[i].push_back(8'(i * 16 + k));
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 3; i++) exp_b.push_back({2'(i), 8'(i * 16 + r)});
      refresh();
      for (int c = 0; c < 18; c++) begin
         #1;
         chk("t6_dst_wr", ifb.dst_wr, c % 2);
         step();
      end
      repeat (3) step();
      chk("t6_exp_empty", exp_b.size(), 0);
      chk("t6_writes", n_wr_b, 9);
      chk("t6_grants", glog_b.size(), 9);
      for (int j = 0; j < 9 && j < glog_b.size(); j++) chk("t6_grant_order", glog_b[j], j % 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
